muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operation set. It is the parametrised successor to the single-cycle combinational ALU, which is generalised to WIDTH-bit operands and extended with multi-cycle sequential arithmetic. It sits beside the ALU in the execute stage, and the controller stalls the PC while `busy` is high. It uses a start/done handshake, a shift-add multiplier, a restoring divider and RISC-V-defined corner-case results.

---
 rtl/muldiv_unit_pkg.sv | 39 +++
 rtl/muldiv_unit_if.sv | 17 +
 rtl/mdu_signfix.sv | 14 +
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// RV32M funct3 op encodings, latched control payload and op classification helpers.
package muldiv_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MDUOp_mul    = 3'b000,
    MDUOp_mulh   = 3'b001,
    MDUOp_mulhsu = 3'b010,
    MDUOp_mulhu  = 3'b011,
    MDUOp_div    = 3'b100,
    MDUOp_divu   = 3'b101,
    MDUOp_rem    = 3'b110,
    MDUOp_remu   = 3'b111
  } mdu_op_e;

  // Control captured when a request is accepted
  typedef struct packed {
    mdu_op_e op;
    logic    neg_res;   // negate product / quotient
    logic    neg_rem;   // negate remainder
    logic    special;   // corner case resolved without iterating
  } mdu_ctrl_t;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_signed_a(input mdu_op_e op);
    return (op == MDUOp_mulh) || (op == MDUOp_mulhsu) ||
           (op == MDUOp_div)  || (op == MDUOp_rem);
  endfunction

  function automatic logic op_signed_b(input mdu_op_e op);
    return (op == MDUOp_mulh) || (op == MDUOp_div) || (op == MDUOp_rem);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/done request bus between the execute-stage controller and the multiply/divide unit.
interface muldiv_unit_if import muldiv_unit_pkg::*; #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);

endinterface

// File: rtl/mdu_signfix.sv
// Combinational conditional two's-complement negate; doubles as abs() when neg is the sign bit.
module mdu_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] value_c
);

  always_comb begin
    value_c = neg ? W'((~value) + W'(1)) : value;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider,
// one bit per cycle, with RISC-V corner-case results resolved at acceptance.
module muldiv_unit import muldiv_unit_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  localparam int unsigned W     = WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  mdu_ctrl_t        ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     opnd_q;     // |a| as multiplicand, or |b| as divisor
  logic [2*W-1:0]   acc_q;      // multiply: {partial, multiplier}; divide: low half dividend/quotient
  logic [W-1:0]     rem_q;
  logic [W-1:0]     spec_q;
  logic [W-1:0]     result_q;
  logic             done_q;

  // Operand sign handling at acceptance
  logic         sa_c, sb_c;
  logic [W-1:0] abs_a_c, abs_b_c;

  assign sa_c = op_signed_a(bus.op) & bus.a[W-1];
  assign sb_c = op_signed_b(bus.op) & bus.b[W-1];

  mdu_signfix #(.W(W)) u_abs_a (.value(bus.a), .neg(sa_c), .value_c(abs_a_c));
  mdu_signfix #(.W(W)) u_abs_b (.value(bus.b), .neg(sb_c), .value_c(abs_b_c));

  // Divide-by-zero and signed-overflow results, decided from the raw operands
  logic         b_zero_c, ovf_c, special_c;
  logic [W-1:0] special_res_c;

  always_comb begin
    b_zero_c      = (bus.b == '0);
    ovf_c         = ((bus.op == MDUOp_div) || (bus.op == MDUOp_rem)) &&
                    (bus.a == MIN_VAL) && (bus.b == '1);
    special_c     = op_is_div(bus.op) & (b_zero_c | ovf_c);
    special_res_c = '1;
    if (b_zero_c) begin
      special_res_c = bus.op[1] ? bus.a : '1;
    end else if (ovf_c) begin
      special_res_c = bus.op[1] ? '0 : bus.a;
    end
  end

  // One iteration step of each algorithm
  logic [W:0] mul_sum_c;
  logic [W:0] div_shift_c, div_diff_c;
  logic       div_ge_c;

  always_comb begin
    mul_sum_c   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift_c = {rem_q, acc_q[W-1]};
    div_diff_c  = div_shift_c - {1'b0, opnd_q};
    div_ge_c    = ~div_diff_c[W];
  end

  // Result sign fix and selection
  logic [2*W-1:0] prod_fix_c;
  logic [W-1:0]   quot_fix_c, rem_fix_c, final_c;

  mdu_signfix #(.W(2*W)) u_fix_prod (.value(acc_q), .neg(ctrl_q.neg_res), .value_c(prod_fix_c));
  mdu_signfix #(.W(W))   u_fix_quot (.value(acc_q[W-1:0]), .neg(ctrl_q.neg_res), .value_c(quot_fix_c));
  mdu_signfix #(.W(W))   u_fix_rem  (.value(rem_q), .neg(ctrl_q.neg_rem), .value_c(rem_fix_c));

  always_comb begin
    final_c = spec_q;
    if (!ctrl_q.special) begin
      case (ctrl_q.op)
        MDUOp_mul:                             final_c = prod_fix_c[W-1:0];
        MDUOp_mulh, MDUOp_mulhsu, MDUOp_mulhu: final_c = prod_fix_c[2*W-1:W];
        MDUOp_div, MDUOp_divu:                 final_c = quot_fix_c;
        default:                               final_c = rem_fix_c;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = special_c ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(W-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      spec_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          ctrl_q.op      <= bus.op;
          ctrl_q.neg_res <= sa_c ^ sb_c;
          ctrl_q.neg_rem <= sa_c;
          ctrl_q.special <= special_c;
          spec_q         <= special_res_c;
          opnd_q         <= op_is_div(bus.op) ? abs_b_c : abs_a_c;
          acc_q          <= {W'(0), (op_is_div(bus.op) ? abs_a_c : abs_b_c)};
          rem_q          <= '0;
          cnt_q          <= '0;
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!op_is_div(ctrl_q.op)) begin
            acc_q <= {mul_sum_c, acc_q[W-1:1]};
          end else begin
            acc_q[W-1:0] <= {acc_q[W-2:0], div_ge_c};
            rem_q        <= div_ge_c ? div_diff_c[W-1:0] : div_shift_c[W-1:0];
          end
        end
        DONE: begin
          result_q <= final_c;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an integer-arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst, rst8;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst),  .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8), .bus(bus8));

  typedef struct {
    logic [31:0] res;
    longint      due;
    string       name;
  } exp_t;

  exp_t   sb32[$];
  exp_t   sb8[$];
  exp_t   e32, e8;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on w-bit values
  function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                       input logic [31:0] a_in, input logic [31:0] b_in,
                                       output int lat);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned ua   = {32'd0, a_in} & mask;
    longint unsigned ub   = {32'd0, b_in} & mask;
    longint sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    longint sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    longint minv = -(longint'(1) << (w-1));
    bit     ovf  = (sa == minv) && (sb == -1);
    longint p;
    longint unsigned r;
    lat = w + 1;
    case (op)
      3'd0: begin p = sa * sb; r = longint'(p) & mask; end
      3'd1: begin p = sa * sb; r = (longint'(p) >> w) & mask; end
      3'd2: begin p = sa * longint'(ub); r = (longint'(p) >> w) & mask; end
      3'd3: r = ((ua * ub) >> w) & mask;
      3'd4: r = (ub == 0) ? mask : ovf ? ua : longint'(sa / sb) & mask;
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : ovf ? 64'd0 : longint'(sa % sb) & mask;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    if (op[2] && (ub == 0 || (!op[0] && ovf))) lat = 1;
    return r[31:0];
  endfunction

  // Wait for the unit to be idle, present one request, push its expectation
  task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat,
                       input string name, output longint acc_edge);
    int guard = 0;
    @(negedge clk);
    while ((w8 ? bus8.busy : bus32.busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    acc_edge = -1;
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s: unit still busy after %0d cycles", name, guard);
    end else begin
      acc_edge = cyc + 1;
      if (w8) begin
        bus8.start = 1'b1; bus8.op = mdu_op_e'(op); bus8.a = a[7:0]; bus8.b = b[7:0];
        sb8.push_back('{res, acc_edge + longint'(lat), name});
      end else begin
        bus32.start = 1'b1; bus32.op = mdu_op_e'(op); bus32.a = a; bus32.b = b;
        sb32.push_back('{res, acc_edge + longint'(lat), name});
      end
      @(posedge clk);
      #1;
      // Operands may change freely once accepted
      bus8.start  = 1'b0; bus8.a  = 8'($urandom);  bus8.b  = 8'($urandom);
      bus32.start = 1'b0; bus32.a = $urandom;      bus32.b = $urandom;
      bus32.op    = mdu_op_e'(3'($urandom));
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d responses never arrived", sb32.size(), sb8.size());
      sb32.delete();
      sb8.delete();
    end
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'd1 << (w - 1);
      4:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return (w == 32) ? v : (v & ((32'd1 << w) - 32'd1));
  endfunction

  // Monitor: pop and compare whenever a unit pulses done
  always @(negedge clk) begin
    if (bus32.done) begin
      if (sb32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32: unexpected done, result 0x%h", bus32.result);
      end else begin
        e32 = sb32.pop_front();
        check({e32.name, "_res"}, bus32.result, e32.res);
        check({e32.name, "_done_cycle"}, 32'(cyc), 32'(e32.due));
      end
    end
    if (bus8.done) begin
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8: unexpected done, result 0x%h", bus8.result);
      end else begin
        e8 = sb8.pop_front();
        check({e8.name, "_res"}, {24'd0, bus8.result}, e8.res);
        check({e8.name, "_done_cycle"}, 32'(cyc), 32'(e8.due));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    longint      e1, e2;
    logic [2:0]  op;
    logic [31:0] a, b, r;
    int          lat, w;

    bus32.start = 1'b0; bus32.op = MDUOp_mul; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.op  = MDUOp_mul; bus8.a  = '0; bus8.b  = '0;
    rst = 1'b1;
    rst8 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy32",   {31'd0, bus32.busy}, 32'd0);
    check("reset_done32",   {31'd0, bus32.done}, 32'd0);
    check("reset_result32", bus32.result, 32'd0);
    check("reset_busy8",    {31'd0, bus8.busy}, 32'd0);
    check("reset_result8",  {24'd0, bus8.result}, 32'd0);
    rst = 1'b0;
    rst8 = 1'b0;

    // Directed cases, issued back to back
    issue(0, 3'd0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 33, "mul_neg7x6", e1);
    issue(0, 3'd1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 33, "mulh_neg7x6", e2);
    check("spacing_normal", 32'(e2 - e1), 32'd34);
    issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_neg7_2", e1);
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_neg7_2", e1);
    issue(0, 3'd5, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 33, "divu_big", e1);
    issue(0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0", e1);
    issue(0, 3'd7, 32'd5, 32'd0, 32'd5, 1, "remu_by0", e2);
    check("spacing_special", 32'(e2 - e1), 32'd2);
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", e1);
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf", e1);
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1", e1);
    issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max", e1);

    // Start pulsed while busy must be ignored
    issue(0, 3'd0, 32'd1234, 32'd5678, 32'd7006652, 33, "mul_busy_start", e1);
    repeat (5) @(negedge clk);
    bus32.start = 1'b1; bus32.op = MDUOp_div; bus32.a = 32'd5; bus32.b = 32'd0;
    @(negedge clk);
    bus32.start = 1'b0;
    drain();

    // Reset in the middle of CALC aborts with no done
    issue(0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 33, "mulh_aborted", e1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_busy",   {31'd0, bus32.busy}, 32'd0);
    check("midreset_done",   {31'd0, bus32.done}, 32'd0);
    check("midreset_result", bus32.result, 32'd0);
    rst = 1'b0;
    sb32.delete();
    repeat (40) @(negedge clk);

    // WIDTH=8 directed
    issue(1, 3'd0, 32'h7F, 32'h7F, 32'h01, 9, "w8_mul_7f", e1);
    issue(1, 3'd3, 32'h7F, 32'h7F, 32'h3F, 9, "w8_mulhu_7f", e2);
    check("spacing_w8", 32'(e2 - e1), 32'd10);

    // Randomized against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom);
      a = pick(32);
      b = pick(32);
      r = model(32, op, a, b, lat);
      issue(0, op, a, b, r, lat, "rnd32", e1);
    end
    for (int i = 0; i < 80; i++) begin
      w = 8;
      op = 3'($urandom);
      a = pick(w);
      b = pick(w);
      r = model(w, op, a, b, lat);
      issue(1, op, a, b, r, lat, "rnd8", e1);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
